// File: rtl/mesh_generator.sv
// mesh_generator: 16-terminal packet fabric standing in for a 4x4 router mesh.
// A round-robin arbiter pulls one packet at a time from the source terminals.
// It decodes the {row,col} header field and writes the packet, unchanged, into
// the show-ahead output FIFO of every destination terminal.
//
// Ports
//   clk, reset         rising-edge clock, async active-high reset
//   pndng_i_in[i]      source terminal i has a head packet
//   data_out_i_in[i]   head packet of source terminal i
//   popin[i]           one-cycle pop strobe back to source terminal i
//   pndng[j]           output FIFO j non-empty
//   data_out[j]        head of output FIFO j (0 when empty)
//   pop[j]             consumer pops output FIFO j

// Show-ahead output FIFO. One instance per destination terminal.
module mg_ofifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic         full,
  output logic         pndng,
  output logic [W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [CW-1:0]           cnt;
  logic                    do_rd, do_wr;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pndng = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));
  assign do_rd = rd && pndng;                 // pop on empty is ignored
  assign do_wr = wr && (!full || do_rd);      // a pop on the same edge frees the slot
  assign dout  = pndng ? mem[rp] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= nxt(wp);
      if (do_rd) rp <= nxt(rp);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage has no reset; dout is gated by pndng.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end
endmodule

module mesh_generator #(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = {8{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              pndng_i_in,
  input  logic [15:0][pckg_sz-1:0] data_out_i_in,
  output logic [15:0]              popin,
  output logic [15:0]              pndng,
  output logic [15:0][pckg_sz-1:0] data_out,
  input  logic [15:0]              pop
);
  localparam int NT = 2 * ROWS + 2 * COLUMS;

  typedef enum logic {SCAN, ACCEPT} st_t;

  typedef struct packed {
    logic [NT-1:0]      mask;
    logic [pckg_sz-1:0] data;
  } wr_req_t;

  // {row,col} of terminal t. The order is top edge, left edge, bottom edge,
  // then right edge. The corners (0,0),(0,5),(5,0),(5,5) are not terminals.
  function automatic logic [7:0] term_addr(input int t);
    logic [3:0] r, c;
    if (t < COLUMS) begin
      r = 4'd0;                       c = 4'(t + 1);
    end else if (t < COLUMS + ROWS) begin
      r = 4'(t - COLUMS + 1);         c = 4'd0;
    end else if (t < 2 * COLUMS + ROWS) begin
      r = 4'(ROWS + 1);               c = 4'(t - COLUMS - ROWS + 1);
    end else begin
      r = 4'(t - 2 * COLUMS - ROWS + 1); c = 4'(COLUMS + 1);
    end
    return {r, c};
  endfunction

  // The destination mask is all-zero for an unmapped address, so such a
  // packet is popped and dropped.
  function automatic logic [NT-1:0] dest_of(input logic [7:0] a, input int src);
    logic [NT-1:0] m;
    m = '0;
    if (a == bdcst) begin
      m      = '1;
      m[src] = 1'b0;
    end else begin
      for (int t = 0; t < NT; t++)
        if (a == term_addr(t)) m[t] = 1'b1;
    end
    return m;
  endfunction

  st_t                st, st_n;
  logic [3:0]         sel, sel_n, last, last_n, idx;
  logic               found;
  logic [NT-1:0]      full, elig;
  logic [NT-1:0][NT-1:0] dmask;
  wr_req_t            wr;

  genvar g;
  generate
    for (g = 0; g < NT; g++) begin : g_term
      assign dmask[g] = dest_of(data_out_i_in[g][pckg_sz-9 -: 8], g);
      // Only a source whose destinations all have room is eligible. This lets
      // a blocked port be skipped without stalling the others.
      assign elig[g]  = pndng_i_in[g] && ((dmask[g] & full) == '0);

      mg_ofifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_ofifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr.mask[g]),
        .din   (wr.data),
        .rd    (pop[g]),
        .full  (full[g]),
        .pndng (pndng[g]),
        .dout  (data_out[g])
      );
    end
  endgenerate

  always_comb begin
    st_n   = st;
    sel_n  = sel;
    last_n = last;
    found  = 1'b0;
    idx    = '0;
    case (st)
      SCAN: begin
        // The search starts at last+1 and ends at last itself (k=16 wraps to 0).
        for (int k = 1; k <= NT; k++) begin
          idx = last + 4'(k);
          if (!found && elig[idx]) begin
            found = 1'b1;
            sel_n = idx;
          end
        end
        if (found) st_n = ACCEPT;
      end
      ACCEPT: begin
        st_n   = SCAN;
        last_n = sel;
      end
      default: st_n = SCAN;
    endcase
  end

  // The write happens on the edge that closes ACCEPT. A reset during ACCEPT
  // clears the state asynchronously, so the packet is never written.
  assign wr.mask = (st == ACCEPT) ? dmask[sel] : '0;
  assign wr.data = data_out_i_in[sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= SCAN;
      sel   <= '0;
      last  <= 4'hF;
      popin <= '0;
    end else begin
      st    <= st_n;
      sel   <= sel_n;
      last  <= last_n;
      popin <= (st_n == ACCEPT) ? (16'd1 << sel_n) : '0;
    end
  end
endmodule

// File: tb/tb_mesh_generator.sv
module tb_mesh_generator;
  localparam int PW    = 40;
  localparam int NT    = 16;
  localparam int DEPTH = 4;
  localparam logic [7:0] ADDR [0:NT-1] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
    8'h51, 8'h52, 8'h53, 8'h54, 8'h15, 8'h25, 8'h35, 8'h45};

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NT-1:0]          pndng_i_in, popin, pndng, pop;
  logic [NT-1:0][PW-1:0]  data_out_i_in, data_out;

  mesh_generator #(.ROWS(4), .COLUMS(4), .pckg_sz(PW), .fifo_depth(DEPTH),
                   .bdcst(8'hFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .pndng         (pndng),
    .data_out      (data_out),
    .pop           (pop)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] src_q [NT][$];   // per-source pending packets
  logic [PW-1:0] exp_q [NT][$];   // scoreboard per output FIFO
  logic [NT-1:0] src_flag, pop_en, pop_once, prev_popin;
  int            grant_id[$], grant_cyc[$];
  int            cyc, total, bad;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [7:0] a, input logic [22:0] pl);
    return {8'hA5 ^ pl[7:0], a, pl[0], pl};
  endfunction

  function automatic logic [NT-1:0] mdest(input logic [PW-1:0] p, input int src);
    logic [7:0]    a;
    logic [NT-1:0] m;
    a = p[PW-9 -: 8];
    m = '0;
    if (a == 8'hFF) begin
      m = '1; m[src] = 1'b0;
    end else
      for (int t = 0; t < NT; t++) if (ADDR[t] == a) m[t] = 1'b1;
    return m;
  endfunction

  function automatic int out_pending();
    int s = 0;
    for (int j = 0; j < NT; j++) s += exp_q[j].size();
    return s;
  endfunction

  // One negedge: check outputs against the scoreboard, record grants, drive inputs.
  task automatic tick();
    logic [PW-1:0] p;
    logic [NT-1:0] m;
    @(negedge clk);
    cyc++;
    if (reset) begin
      for (int j = 0; j < NT; j++) begin exp_q[j].delete(); src_q[j].delete(); end
      src_flag = '0; pop = '0; prev_popin = '0;
      pndng_i_in = '0; data_out_i_in = '0;
      chk("rst_pndng", pndng, 0);
      chk("rst_popin", popin, 0);
      chk("rst_data", |data_out, 0);
      return;
    end
    for (int i = 0; i < NT; i++)
      if (src_flag[i]) void'(src_q[i].pop_front());
    src_flag = '0;
    for (int j = 0; j < NT; j++) begin
      chk($sformatf("pndng%0d", j), pndng[j], exp_q[j].size() != 0);
      if (exp_q[j].size() != 0) begin
        chk($sformatf("data%0d", j), data_out[j], exp_q[j][0]);
        if (pop_en[j] || pop_once[j]) begin
          void'(exp_q[j].pop_front());
          pop[j] = 1'b1; pop_once[j] = 1'b0;
        end else pop[j] = 1'b0;
      end else begin
        chk($sformatf("empty_data%0d", j), data_out[j], 0);
        pop[j] = pop_en[j];  // blind pops on empty must be ignored
      end
    end
    if (popin != 0) begin
      chk("popin_onehot", $countones(popin), 1);
      chk("popin_b2b", popin & prev_popin, 0);
    end
    for (int i = 0; i < NT; i++) begin
      if (popin[i]) begin
        chk($sformatf("popin_pend%0d", i), pndng_i_in[i], 1);
        if (src_q[i].size() != 0) begin
          p = src_q[i][0];
          m = mdest(p, i);
          for (int d = 0; d < NT; d++) if (m[d]) exp_q[d].push_back(p);
          src_flag[i] = 1'b1;
          grant_id.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
    prev_popin = popin;
    for (int i = 0; i < NT; i++) begin
      pndng_i_in[i]    = (src_q[i].size() != 0);
      data_out_i_in[i] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic wait_src(input int i, input int bound, input string tag);
    int n = 0;
    while (src_q[i].size() != 0 && n < bound) begin tick(); n++; end
    chk(tag, src_q[i].size(), 0);
  endtask

  task automatic drain(input int bound, input string tag);
    int n = 0;
    while (out_pending() != 0 && n < bound) begin tick(); n++; end
    chk(tag, out_pending(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, n;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; pop = '0; pndng_i_in = '0; data_out_i_in = '0;
    src_flag = '0; pop_en = '1; pop_once = '0; prev_popin = '0;
    repeat (3) tick();
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("post_rst_pndng", pndng, 0);
    chk("post_rst_popin", popin, 0);
    chk("post_rst_data", |data_out, 0);

    // Unicast: terminal 0 -> (5,2) = terminal 9
    src_q[0].push_back(mk(8'h52, 23'h123));
    wait_src(0, 50, "uni_grant");
    drain(20, "uni_drain");

    // Broadcast from terminal 5
    src_q[5].push_back(mk(8'hFF, 23'h5A5A5));
    wait_src(5, 50, "bc_grant");
    drain(20, "bc_drain");

    // Reset in the middle of traffic, landing in an ACCEPT cycle
    pop_en = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 2; k++) src_q[i].push_back(mk(ADDR[(i + 3 + k) % NT], 23'(i * 4 + k)));
    repeat (6) tick();
    n = 0;
    while (popin == 0 && n < 50) begin tick(); n++; end
    chk("rst_found_accept", popin != 0, 1);
    reset = 1'b1;
    #1;
    chk("rst_async_popin", popin, 0);
    chk("rst_async_pndng", pndng, 0);
    chk("rst_async_data", |data_out, 0);
    repeat (3) tick();
    @(posedge clk); #1 reset = 1'b0;
    pop_en = '1;
    tick();
    chk("rst_release_pndng", pndng, 0);
    chk("rst_release_popin", popin, 0);

    // Fairness: all 16 sources busy, rotating targets, from a fresh reset
    g0 = grant_id.size();
    for (int i = 0; i < NT; i++)
      for (int k = 0; k < 4; k++) src_q[i].push_back(mk(ADDR[(i + k + 1) % NT], 23'(i * 16 + k)));
    for (int i = 0; i < NT; i++) wait_src(i, 200, $sformatf("rr_done%0d", i));
    chk("rr_count", grant_id.size() - g0, 64);
    if (grant_id.size() - g0 == 64) begin
      chk("rr_first", grant_id[g0], 0);
      for (int q = g0 + 1; q < g0 + 64; q++) begin
        chk("rr_order", grant_id[q], (grant_id[q - 1] + 1) % NT);
        chk("rr_gap", grant_cyc[q] - grant_cyc[q - 1], 2);
      end
    end
    drain(20, "rr_drain");

    // Backpressure on output 12
    pop_en[12] = 1'b0;
    for (int k = 0; k < 6; k++) src_q[0].push_back(mk(8'h15, 23'h700 + 23'(k)));
    for (int k = 0; k < 3; k++) src_q[1].push_back(mk(8'h04, 23'h800 + 23'(k)));
    repeat (60) tick();
    chk("bp_fill", exp_q[12].size(), DEPTH);
    chk("bp_held", src_q[0].size(), 2);
    chk("bp_other", src_q[1].size(), 0);
    pop_once[12] = 1'b1;
    repeat (20) tick();
    chk("bp_one_more", src_q[0].size(), 1);
    chk("bp_still_full", exp_q[12].size(), DEPTH);
    pop_en[12] = 1'b1;
    wait_src(0, 50, "bp_release");
    drain(30, "bp_drain");

    // Invalid address: popped and dropped
    src_q[2].push_back(mk(8'h77, 23'h3C3C));
    wait_src(2, 50, "inv_grant");
    repeat (4) tick();
    chk("inv_quiet", pndng, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
